// File: rtl/bird_referee_if.sv
// Bus between the bird referee and its neighbours: bird column, obstacle column,
// start key in; game state, freeze gate and BCD scores out.
interface bird_referee_if;
  logic [15:0] lights;
  logic [15:0] pipe;
  logic        pipe_valid;
  logic        start;
  logic        playing;
  logic        game_over;
  logic        freeze;
  logic [7:0]  score;
  logic [7:0]  best;

  modport master (
    output lights, pipe, pipe_valid, start,
    input  playing, game_over, freeze, score, best
  );

  modport slave (
    input  lights, pipe, pipe_valid, start,
    output playing, game_over, freeze, score, best
  );
endinterface

// File: rtl/bird_referee.sv
// Game-rule checker: crash detection, BCD pipe-pass score, best score and freeze gate.
// Define BIRD_GROUND_KILL_EN to make touching the ground row a crash.
module bird_referee (
  input  logic          clk,
  input  logic          reset,
  bird_referee_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_e;

  state_e     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] best_q,  best_d;
  logic       pv_q,    pv_d;
  logic       hit, empty, crash, fall;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] ones, tens;
    if (v[3:0] == 4'd9) begin
      ones = 4'd0;
      tens = v[7:4] + 4'd1;
    end else begin
      ones = v[3:0] + 4'd1;
      tens = v[7:4];
    end
    return {tens, ones};
  endfunction

  always_comb begin
    hit   = bus.pipe_valid && (|(bus.lights & bus.pipe));
    empty = (bus.lights == 16'h0000);
`ifdef BIRD_GROUND_KILL_EN
    crash = hit || empty || bus.lights[15];
`else
    crash = hit || empty;
`endif
    fall = pv_q && !bus.pipe_valid;

    state_d = state_q;
    score_d = score_q;
    best_d  = best_q;
    pv_d    = pv_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PLAY;
          score_d = 8'h00;
          pv_d    = 1'b0;
        end
      end
      PLAY: begin
        pv_d = bus.pipe_valid;
        // A crash on the same cycle as a pass forfeits the point.
        if (crash)
          state_d = OVER;
        else if (fall && score_q != 8'h99)
          score_d = bcd_inc(score_q);
      end
      OVER: begin
        // Packed BCD orders the same as binary, so a plain compare is tens-first.
        if (score_q > best_q)
          best_d = score_q;
        if (bus.start) begin
          state_d = PLAY;
          score_d = 8'h00;
          pv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      score_q <= 8'h00;
      best_q  <= 8'h00;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      best_q  <= best_d;
      pv_q    <= pv_d;
    end
  end

  assign bus.playing   = (state_q == PLAY);
  assign bus.game_over = (state_q == OVER);
  assign bus.freeze    = (state_q != PLAY);
  assign bus.score     = score_q;
  assign bus.best      = best_q;

endmodule
